// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg: shared NoC return-channel definitions.
//   Frame codes, length-byte constants, transmitter FSM states, the
//   response-header payload, and byte-formatting helpers.
// ---------------------------------------------------------------------------
package noc_pkg;

  // Frame codes occupy DataR[7:5]; the low five bits are always zero.
  localparam logic [2:0] NOC_IDLE       = 3'b000;
  localparam logic [2:0] NOC_READ       = 3'b001;
  localparam logic [2:0] NOC_READ_RESP  = 3'b010;
  localparam logic [2:0] NOC_WRITE      = 3'b011;
  localparam logic [2:0] NOC_WRITE_RESP = 3'b100;

  // Length byte of a read response is the data byte count.
  localparam logic [7:0] LEN_BYTE_1 = 8'h04;
  localparam logic [7:0] LEN_BYTE_2 = 8'h08;
  localparam logic [7:0] LEN_BYTE_3 = 8'h0C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME,
    ST_RID,
    ST_LEN,
    ST_DATA,
    ST_END_CHK
  } tx_state_t;

  // Queued response request; len is already coerced to 1..3.
  typedef struct packed {
    logic       wr;
    logic [7:0] id;
    logic [1:0] len;
  } resp_hdr_t;

  function automatic logic [7:0] frame_byte(input logic [2:0] code);
    return {code, 5'b00000};
  endfunction

  function automatic logic [7:0] len_byte(input logic [1:0] len);
    case (len)
      2'd2:    return LEN_BYTE_2;
      2'd3:    return LEN_BYTE_3;
      default: return LEN_BYTE_1;
    endcase
  endfunction

  // Byte idx of a word, byte 0 = [7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// ---------------------------------------------------------------------------
// noc_sync_fifo: single-clock FIFO with occupancy count.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   i_push     : write request, ignored (dropped) while full
//   i_wdata    : write data
//   i_pop      : read request, ignored while empty
//   o_rdata    : head entry (valid while o_count != 0)
//   o_full     : DEPTH entries held
//   o_count    : entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module noc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && (r_count != '0);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/noc_resp_tx.sv
// ---------------------------------------------------------------------------
// noc_resp_tx: serializes queued read/write responses onto CmdR/DataR.
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid/req_ready/req_wr/req_id/req_len : response header push
//   rdata_valid/rdata/rdata_full              : read-data word push
//   CmdR, DataR  : registered return channel (idle = 1 / 8'h00)
//   busy         : a packet byte is on the channel
//   ovf          : sticky, a word was dropped because the word FIFO was full
// ---------------------------------------------------------------------------
module noc_resp_tx
  import noc_pkg::*;
#(
  parameter int unsigned HDR_DEPTH  = 4,
  parameter int unsigned DATA_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [7:0]  req_id,
  input  logic [1:0]  req_len,
  input  logic        rdata_valid,
  input  logic [31:0] rdata,
  output logic        rdata_full,
  output logic        CmdR,
  output logic [7:0]  DataR,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned HW  = $bits(resp_hdr_t);
  localparam int unsigned HCW = $clog2(HDR_DEPTH) + 1;
  localparam int unsigned DCW = $clog2(DATA_DEPTH) + 1;

  resp_hdr_t        w_hdr_in;
  resp_hdr_t        w_head;
  logic [HW-1:0]    w_hdr_rdata;
  logic [HCW-1:0]   w_hdr_cnt;
  logic             w_hdr_full;
  logic [31:0]      w_word;
  logic [DCW-1:0]   w_word_cnt;
  logic             w_word_full;

  tx_state_t        r_state;
  logic             r_cmdr;
  logic [7:0]       r_datar;
  logic             r_busy;
  logic             r_ovf;
  logic             r_wr;
  logic [7:0]       r_id;
  logic [1:0]       r_len;
  logic [3:0]       r_byte_cnt;

  logic             w_eligible;
  logic             w_last;
  logic [3:0]       w_next_idx;
  logic             w_pkt_end;
  logic             w_start;
  logic             w_word_pop;

  // Header capture; a zero length is treated as one word.
  always_comb begin
    w_hdr_in     = '0;
    w_hdr_in.wr  = req_wr;
    w_hdr_in.id  = req_id;
    w_hdr_in.len = (req_len == 2'd0) ? 2'd1 : req_len;
  end

  assign w_head = resp_hdr_t'(w_hdr_rdata);

  noc_sync_fifo #(.WIDTH(HW), .DEPTH(HDR_DEPTH)) u_hdr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (req_valid),
    .i_wdata (w_hdr_in),
    .i_pop   (w_start),
    .o_rdata (w_hdr_rdata),
    .o_full  (w_hdr_full),
    .o_count (w_hdr_cnt)
  );

  noc_sync_fifo #(.WIDTH(32), .DEPTH(DATA_DEPTH)) u_word_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (rdata_valid),
    .i_wdata (rdata),
    .i_pop   (w_word_pop),
    .o_rdata (w_word),
    .o_full  (w_word_full),
    .o_count (w_word_cnt)
  );

  // A packet may start only once all of its data words are queued.
  always_comb begin
    w_eligible = 1'b0;
    if (w_hdr_cnt != '0) w_eligible = w_head.wr || (w_word_cnt >= DCW'(w_head.len));
  end

  // The end-of-packet check resolves in the last byte's cycle so that a
  // following packet's frame byte comes out with no idle gap.
  assign w_last     = (r_byte_cnt == 4'({r_len, 2'b00} - 4'd1));
  assign w_next_idx = r_byte_cnt + 4'd1;
  assign w_pkt_end  = ((r_state == ST_RID) && r_wr) ||
                      ((r_state == ST_DATA) && w_last) ||
                      (r_state == ST_END_CHK);
  assign w_start    = w_eligible && ((r_state == ST_IDLE) || w_pkt_end);
  // Pop a word as its byte 3 is loaded; the next load then sees the next word.
  assign w_word_pop = (r_state == ST_DATA) && !w_last && (w_next_idx[1:0] == 2'd3);

  // Transmit FSM; the state names the byte currently on the channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cmdr     <= 1'b1;
      r_datar    <= frame_byte(NOC_IDLE);
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_wr       <= 1'b0;
      r_id       <= '0;
      r_len      <= 2'd1;
      r_byte_cnt <= '0;
    end else begin
      if (rdata_valid && w_word_full) r_ovf <= 1'b1;
      if (w_start) begin
        r_state <= ST_FRAME;
        r_cmdr  <= 1'b1;
        r_datar <= frame_byte(w_head.wr ? NOC_WRITE_RESP : NOC_READ_RESP);
        r_busy  <= 1'b1;
        r_wr    <= w_head.wr;
        r_id    <= w_head.id;
        r_len   <= w_head.len;
      end else if (w_pkt_end) begin
        r_state <= ST_IDLE;
        r_cmdr  <= 1'b1;
        r_datar <= frame_byte(NOC_IDLE);
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_FRAME: begin
            r_state <= ST_RID;
            r_cmdr  <= 1'b0;
            r_datar <= r_id;
          end
          ST_RID: begin
            r_state <= ST_LEN;
            r_datar <= len_byte(r_len);
          end
          ST_LEN: begin
            r_state    <= ST_DATA;
            r_byte_cnt <= '0;
            r_datar    <= word_byte(w_word, 2'd0);
          end
          ST_DATA: begin
            r_byte_cnt <= w_next_idx;
            r_datar    <= word_byte(w_word, w_next_idx[1:0]);
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign req_ready  = !w_hdr_full;
  assign rdata_full = w_word_full;
  assign CmdR       = r_cmdr;
  assign DataR      = r_datar;
  assign busy       = r_busy;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_noc_resp_tx.sv
// ---------------------------------------------------------------------------
// tb_noc_resp_tx: scoreboard bench for noc_resp_tx. Expected channel bytes
// are queued as stimulus is driven; a monitor pops one per non-idle byte.
// ---------------------------------------------------------------------------
module tb_noc_resp_tx;

  typedef struct packed {
    logic       cmdr;
    logic [7:0] data;
    logic       last;
    logic       b2b;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [7:0]  req_id;
  logic [1:0]  req_len;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        rdata_full;
  logic        CmdR;
  logic [7:0]  DataR;
  logic        busy;
  logic        ovf;

  exp_t sb[$];
  int   n_chk;
  int   n_bad;
  int   n_seen;
  logic in_pkt;
  logic prev_last;

  noc_resp_tx #(.HDR_DEPTH(4), .DATA_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_id      (req_id),
    .req_len     (req_len),
    .rdata_valid (rdata_valid),
    .rdata       (rdata),
    .rdata_full  (rdata_full),
    .CmdR        (CmdR),
    .DataR       (DataR),
    .busy        (busy),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    @(negedge clk);
    rdata_valid = 1'b1;
    rdata       = w;
    @(posedge clk);
    #1 rdata_valid = 1'b0;
  endtask

  task automatic push_hdr(input logic wr, input logic [7:0] id, input logic [1:0] len);
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_id    = id;
    req_len   = len;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic exp_write(input logic [7:0] id, input logic b2b);
    sb.push_back('{cmdr: 1'b1, data: 8'h80, last: 1'b0, b2b: b2b});
    sb.push_back('{cmdr: 1'b0, data: id,    last: 1'b1, b2b: 1'b0});
  endtask

  task automatic exp_read(input logic [7:0] id, input int len, input logic [31:0] w0,
                          input logic [31:0] w1, input logic [31:0] w2, input logic b2b);
    logic [31:0] w;
    sb.push_back('{cmdr: 1'b1, data: 8'h40, last: 1'b0, b2b: b2b});
    sb.push_back('{cmdr: 1'b0, data: id,    last: 1'b0, b2b: 1'b0});
    sb.push_back('{cmdr: 1'b0, data: 8'(len * 4), last: 1'b0, b2b: 1'b0});
    for (int i = 0; i < len; i++) begin
      w = (i == 0) ? w0 : ((i == 1) ? w1 : w2);
      for (int b = 0; b < 4; b++)
        sb.push_back('{cmdr: 1'b0, data: w[8*b +: 8], last: (i == len - 1) && (b == 3), b2b: 1'b0});
    end
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || in_pkt) && k < 200) begin
      @(posedge clk);
      k++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(tag, 32'(sb.size()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle"}, {23'd0, CmdR, DataR}, 32'h100);
  endtask

  initial begin
    exp_t e;
    int   n0;
    int   k;
    n_chk = 0; n_bad = 0; n_seen = 0;
    in_pkt = 1'b0; prev_last = 1'b0;
    rst = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_id = '0; req_len = '0;
    rdata_valid = 1'b0; rdata = '0;

    // Monitor: one scoreboard entry per non-idle byte, no gaps inside a packet.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (!(CmdR && DataR == 8'h00)) begin
            n_seen++;
            if (sb.size() == 0) begin
              chk("unexpected_byte", {23'd0, CmdR, DataR}, 32'h100);
              in_pkt = 1'b0;
              prev_last = 1'b0;
            end else begin
              e = sb.pop_front();
              if (e.b2b) chk("b2b_gap", 32'(prev_last), 32'd1);
              chk("byte", {23'd0, CmdR, DataR}, {23'd0, e.cmdr, e.data});
              in_pkt = !e.last;
              prev_last = e.last;
            end
          end else begin
            if (in_pkt && sb.size() != 0) begin
              e = sb.pop_front();
              chk("pkt_gap", {23'd0, CmdR, DataR}, {23'd0, e.cmdr, e.data});
              in_pkt = !e.last;
            end
            prev_last = 1'b0;
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmdr", 32'(CmdR), 32'd1);
    chk("rst_datar", 32'(DataR), 32'h00);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rdata_full", 32'(rdata_full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write response and first-byte latency.
    exp_write(8'h5A, 1'b0);
    push_hdr(1'b1, 8'h5A, 2'd0);
    chk("lat_e0", {23'd0, CmdR, DataR}, 32'h100);
    @(posedge clk);
    #1;
    chk("lat_e1", {23'd0, CmdR, DataR}, 32'h180);
    chk("lat_busy", 32'(busy), 32'd1);
    wait_drain("wr_drain");

    // Read response, one word already present.
    exp_read(8'h07, 1, 32'h11223344, 32'h0, 32'h0, 1'b0);
    push_word(32'h11223344);
    push_hdr(1'b0, 8'h07, 2'd1);
    wait_drain("rd1_drain");

    // Read response, header ahead of its three words.
    push_hdr(1'b0, 8'h12, 2'd3);
    n0 = n_seen;
    push_word(32'hA0A1A2A3);
    repeat (2) @(posedge clk);
    push_word(32'hB0B1B2B3);
    repeat (4) @(posedge clk);
    #1;
    chk("early_frame", 32'(n_seen - n0), 32'd0);
    exp_read(8'h12, 3, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 1'b0);
    push_word(32'hC0C1C2C3);
    wait_drain("rd3_drain");

    // Back-to-back: write response behind a two-word read response.
    exp_read(8'h21, 2, 32'h01020304, 32'h05060708, 32'h0, 1'b0);
    exp_write(8'h01, 1'b1);
    push_word(32'h01020304);
    push_word(32'h05060708);
    push_hdr(1'b0, 8'h21, 2'd2);
    push_hdr(1'b1, 8'h01, 2'd0);
    wait_drain("b2b_drain");

    // Word FIFO overflow, then drain the eight retained words.
    for (int i = 1; i <= 8; i++) push_word(32'hD0D0_D000 | 32'(i));
    chk("wfull_8", 32'(rdata_full), 32'd1);
    chk("ovf_8", 32'(ovf), 32'd0);
    push_word(32'hDEADBEEF);
    chk("ovf_9", 32'(ovf), 32'd1);
    chk("wfull_9", 32'(rdata_full), 32'd1);
    exp_read(8'h41, 3, 32'hD0D0_D001, 32'hD0D0_D002, 32'hD0D0_D003, 1'b0);
    exp_read(8'h42, 3, 32'hD0D0_D004, 32'hD0D0_D005, 32'hD0D0_D006, 1'b1);
    exp_read(8'h43, 2, 32'hD0D0_D007, 32'hD0D0_D008, 32'h0, 1'b1);
    push_hdr(1'b0, 8'h41, 2'd3);
    push_hdr(1'b0, 8'h42, 2'd3);
    push_hdr(1'b0, 8'h43, 2'd2);
    wait_drain("wovf_drain");

    // Header FIFO full; a fifth header is refused.
    push_hdr(1'b0, 8'h30, 2'd1);
    push_hdr(1'b0, 8'h31, 2'd0);
    push_hdr(1'b0, 8'h32, 2'd1);
    chk("hready_3", 32'(req_ready), 32'd1);
    push_hdr(1'b0, 8'h33, 2'd1);
    chk("hready_4", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_id = 8'h34; req_len = 2'd0;
    repeat (2) @(posedge clk);
    #1 req_valid = 1'b0;
    chk("hready_5", 32'(req_ready), 32'd0);
    exp_read(8'h30, 1, 32'hE0E0E0E0, 32'h0, 32'h0, 1'b0);
    exp_read(8'h31, 1, 32'hE1E1E1E1, 32'h0, 32'h0, 1'b0);
    exp_read(8'h32, 1, 32'hE2E2E2E2, 32'h0, 32'h0, 1'b0);
    exp_read(8'h33, 1, 32'hE3E3E3E3, 32'h0, 32'h0, 1'b0);
    push_word(32'hE0E0E0E0);
    push_word(32'hE1E1E1E1);
    push_word(32'hE2E2E2E2);
    push_word(32'hE3E3E3E3);
    wait_drain("hovf_drain");

    // Reset in the middle of a read response's data bytes.
    exp_read(8'h55, 3, 32'h0A0B0C0D, 32'h1A1B1C1D, 32'h2A2B2C2D, 1'b0);
    push_word(32'h0A0B0C0D);
    push_word(32'h1A1B1C1D);
    push_word(32'h2A2B2C2D);
    n0 = n_seen;
    push_hdr(1'b0, 8'h55, 2'd3);
    k = 0;
    while ((n_seen - n0) < 5 && k < 50) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("mid_data_reached", 32'(n_seen - n0 >= 5), 32'd1);
    chk("mid_data_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    sb.delete();
    in_pkt = 1'b0;
    prev_last = 1'b0;
    #1;
    chk("arst_cmdr", 32'(CmdR), 32'd1);
    chk("arst_datar", 32'(DataR), 32'h00);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_wfull", 32'(rdata_full), 32'd0);
    exp_write(8'h66, 1'b0);
    push_hdr(1'b1, 8'h66, 2'd0);
    wait_drain("post_rst_drain");
    chk("post_rst_ovf", 32'(ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
